// File: rtl/stack_ctrl.sv
// stack_ctrl: command sequencer for the push/pop side of a LIFO stack.
//
// Accepts push/pop requests over a valid/ready handshake. It issues a single
// registered strobe to the stack, waits for the stack's registered pop data,
// and returns one response per request. Rejected requests (push when full,
// pop when empty) return rsp_err = 1 and rsp_data = 0. No strobe is issued
// for them.
//
// Optional feature: define STACK_CTRL_STATS_EN to add the saturating
// statistics counters push_cnt, pop_cnt and err_cnt.
//
// Ports:
//   clk, rstn                    clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_op, req_data             0 = push, 1 = pop; data used only for push
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_err            popped data or push echo; rejection flag
//   stk_push, stk_pop, stk_din   one-cycle strobes and data to the stack
//   stk_dout, stk_full, stk_empty  stack registered data and status
//   level                        shadow occupancy, saturating at 0 and DEPTH
//   push_cnt, pop_cnt, err_cnt   statistics (STACK_CTRL_STATS_EN only)
//
// The stack must share rstn so that both sides restart empty.
//
// state | meaning
// IDLE  | ready for a request; full/empty sampled on accept
// ISSUE | strobe to the stack is high for this one cycle
// WAIT  | stack output now holds the popped value; capture it
// RESP  | response valid, held until rsp_ready

module stack_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int CNT_W = 8,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [LW-1:0]    level
`ifdef STACK_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] push_cnt,
  output logic [CNT_W-1:0] pop_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  state_t state;
  logic   op_q;
  logic   accept_ok;

  assign req_ready = (state == IDLE);

  // Decided from the live stack status, not from level.
  assign accept_ok = req_op ? !stk_empty : !stk_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      op_q      <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      level     <= '0;
    end else begin
      // Strobes last exactly one cycle.
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            stk_din <= req_data;
            if (accept_ok) begin
              stk_push <= !req_op;
              stk_pop  <= req_op;
              state    <= ISSUE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= RESP;
            end
          end
        end
        ISSUE: begin
          if (!op_q) begin
            if (level != LVL_MAX) level <= level + 1'b1;
            rsp_data  <= stk_din;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            if (level != '0) level <= level - 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          // The stack registered the popped entry on the ISSUE edge.
          rsp_data  <= stk_dout;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STACK_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      if (stk_push && push_cnt != CNT_MAX) push_cnt <= push_cnt + 1'b1;
      if (stk_pop && pop_cnt != CNT_MAX)   pop_cnt  <= pop_cnt + 1'b1;
      if (state == IDLE && req_valid && !accept_ok && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
